// File: rtl/demultiplexer4_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: occupancy state encoding,
// lane geometry and the one-hot lane decode helper.
package demultiplexer4_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    // Encoding 2'd3 is never entered; the FSM treats it as EMPTY if it ever appears.
    typedef enum logic [1:0] {
        DEMUX_EMPTY = 2'd0,
        DEMUX_ONE   = 2'd1,
        DEMUX_TWO   = 2'd2
    } demux_state_e;

    function automatic logic [LANES-1:0] laneDecode(input logic [SEL_W-1:0] sel);
        laneDecode = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demultiplexer4_skid_buffer2.sv
// Two-entry {sel,data} skid buffer with occupancy FSM; entry0 is the head,
// entry1 only fills when the head is stalled while a new word arrives.
module skid_buffer2
    import demultiplexer4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] inData_i,
    input  logic [SEL_W-1:0] inSel_i,
    output logic             inReady_o,
    output logic             headValid_o,
    output logic [WIDTH-1:0] headData_o,
    output logic [SEL_W-1:0] headSel_o
);

    demux_state_e     state_q,     state_d;
    logic [WIDTH-1:0] headData_q,  headData_d;
    logic [SEL_W-1:0] headSel_q,   headSel_d;
    logic [WIDTH-1:0] skidData_q,  skidData_d;
    logic [SEL_W-1:0] skidSel_q,   skidSel_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DEMUX_EMPTY;
            headData_q <= '0;
            headSel_q  <= '0;
            skidData_q <= '0;
            skidSel_q  <= '0;
        end else begin
            state_q    <= state_d;
            headData_q <= headData_d;
            headSel_q  <= headSel_d;
            skidData_q <= skidData_d;
            skidSel_q  <= skidSel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        headData_d = headData_q;
        headSel_d  = headSel_q;
        skidData_d = skidData_q;
        skidSel_d  = skidSel_q;

        case (state_q)
            DEMUX_EMPTY: begin
                if (push_i) begin
                    state_d    = DEMUX_ONE;
                    headData_d = inData_i;
                    headSel_d  = inSel_i;
                end
            end
            DEMUX_ONE: begin
                if (push_i && pop_i) begin
                    headData_d = inData_i;
                    headSel_d  = inSel_i;
                end else if (push_i) begin
                    state_d    = DEMUX_TWO;
                    skidData_d = inData_i;
                    skidSel_d  = inSel_i;
                end else if (pop_i) begin
                    state_d    = DEMUX_EMPTY;
                end
            end
            DEMUX_TWO: begin
                // Full: push is impossible because inReady_o is low here.
                if (pop_i) begin
                    state_d    = DEMUX_ONE;
                    headData_d = skidData_q;
                    headSel_d  = skidSel_q;
                end
            end
            default: begin
                state_d = DEMUX_EMPTY;
            end
        endcase
    end

    assign inReady_o   = (state_q != DEMUX_TWO);
    assign headValid_o = (state_q == DEMUX_ONE) || (state_q == DEMUX_TWO);
    assign headData_o  = headData_q;
    assign headSel_o   = headSel_q;

endmodule

// File: rtl/demultiplexer4.sv
// Registered 1-to-4 demultiplexer: steers each word of one valid/ready stream
// to exactly one of four lanes in strict FIFO order.
module demultiplexer4
    import demultiplexer4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready
);

    logic push;
    logic pop;
    logic headValid;

    assign push = in_valid & in_ready;

    // Only the head lane's ready matters, which is what gives head-of-line blocking.
    assign pop = headValid & out_ready[out_sel];

    assign out_valid = headValid ? laneDecode(out_sel) : '0;

    skid_buffer2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .inData_i    (in_data),
        .inSel_i     (in_sel),
        .inReady_o   (in_ready),
        .headValid_o (headValid),
        .headData_o  (out_data),
        .headSel_o   (out_sel)
    );

endmodule

// File: tb/tb_demultiplexer4.sv
// Directed and scoreboarded checks for demultiplexer4: reset, single word,
// streaming, backpressure, head-of-line blocking and random push/pop traffic.
module tb_demultiplexer4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } word_t;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int nAssert;
    int nFail;

    demultiplexer4 #(
        .WIDTH (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [31:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAssert++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkHead(input string tag, input logic [3:0] expValid,
                             input logic [31:0] expData, input logic expReady);
        checkOutput({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, expValid});
        checkOutput({tag, ".out_data"},  out_data, expData);
        checkOutput({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, expReady});
    endtask

    word_t       model[$];
    word_t       w;
    logic [3:0]  expValid;
    logic        doPush;
    logic        doPop;

    initial begin
        nAssert = 0;
        nFail   = 0;
        reset   = 1'b1;
        applyStimulus(1'b0, 2'bxx, 32'hxxxxxxxx, 4'b0000);
        #2;
        $display("[TB] reset state");
        checkHead("reset", 4'b0000, 32'h0, 1'b1);
        checkOutput("reset.out_sel", {30'd0, out_sel}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkHead("idleXsel", 4'b0000, 32'h0, 1'b1);

        $display("[TB] single word");
        applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 4'b1111);
        tick();
        checkHead("single", 4'b0100, 32'hDEADBEEF, 1'b1);
        checkOutput("single.out_sel", {30'd0, out_sel}, 32'd2);
        applyStimulus(1'b0, 2'bxx, 32'hxxxxxxxx, 4'b1111);
        tick();
        checkOutput("single.drained", {28'd0, out_valid}, 32'd0);

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'(i % 4), 32'hA000_0000 + 32'(i), 4'b1111);
            tick();
            checkHead($sformatf("stream%0d", i), 4'b0001 << (i % 4),
                      32'hA000_0000 + 32'(i), 1'b1);
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111);
        tick();
        checkOutput("stream.drained", {28'd0, out_valid}, 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 2'd1, 32'hB000_0000, 4'b1101);
        tick();
        checkHead("bp.first", 4'b0010, 32'hB000_0000, 1'b1);
        applyStimulus(1'b1, 2'd0, 32'hB000_0001, 4'b1101);
        tick();
        checkHead("bp.full", 4'b0010, 32'hB000_0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hB000_0002, 4'b1101);
        tick();
        checkHead("bp.stable", 4'b0010, 32'hB000_0000, 1'b0);
        out_ready = 4'b1111;
        tick();
        checkHead("bp.drain1", 4'b0001, 32'hB000_0001, 1'b1);
        tick();
        checkHead("bp.drain2", 4'b0100, 32'hB000_0002, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111);
        tick();
        checkOutput("bp.drained", {28'd0, out_valid}, 32'd0);

        $display("[TB] head-of-line blocking");
        applyStimulus(1'b1, 2'd3, 32'hC000_0000, 4'b0001);
        tick();
        checkHead("hol.head", 4'b1000, 32'hC000_0000, 1'b1);
        applyStimulus(1'b1, 2'd0, 32'hC000_0001, 4'b0001);
        tick();
        checkHead("hol.blocked", 4'b1000, 32'hC000_0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0001);
        tick();
        checkHead("hol.still", 4'b1000, 32'hC000_0000, 1'b0);
        out_ready = 4'b1001;
        tick();
        checkHead("hol.lane0", 4'b0001, 32'hC000_0001, 1'b1);
        tick();
        checkOutput("hol.drained", {28'd0, out_valid}, 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 2'd1, 32'hD000_0000, 4'b0000);
        tick();
        applyStimulus(1'b1, 2'd3, 32'hD000_0001, 4'b0000);
        tick();
        checkHead("rst.beforeFull", 4'b0010, 32'hD000_0000, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        checkHead("rst.async", 4'b0000, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 2'd2, 32'hD000_0002, 4'b1111);
        tick();
        checkHead("rst.firstPush", 4'b0100, 32'hD000_0002, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111);
        tick();
        checkOutput("rst.noStale", {28'd0, out_valid}, 32'd0);

        $display("[TB] random push/pop scoreboard");
        model.delete();
        for (int c = 0; c < 100; c++) begin
            expValid = (model.size() > 0) ? (4'b0001 << model[0].sel) : 4'b0000;
            checkOutput($sformatf("rnd%0d.out_valid", c), {28'd0, out_valid}, {28'd0, expValid});
            checkOutput($sformatf("rnd%0d.in_ready", c), {31'd0, in_ready},
                        {31'd0, model.size() < 2});
            if (model.size() > 0) begin
                checkOutput($sformatf("rnd%0d.out_data", c), out_data, model[0].data);
                checkOutput($sformatf("rnd%0d.out_sel", c), {30'd0, out_sel}, {30'd0, model[0].sel});
            end
            w.sel  = 2'($urandom_range(0, 3));
            w.data = $urandom;
            applyStimulus(($urandom_range(0, 7) != 0), w.sel, w.data, 4'($urandom));
            if (model.size() > 0 && $urandom_range(0, 3) != 0)
                out_ready[model[0].sel] = 1'b1;
            doPush = in_valid && (model.size() < 2);
            doPop  = (model.size() > 0) && out_ready[model[0].sel];
            if (doPop)
                void'(model.pop_front());
            if (doPush)
                model.push_back(w);
            tick();
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
